window_pixel_writer: RTL and testbench
======================================

# window_pixel_writer

Write-side companion of the display-window read control in the VGA display system. It accepts a stream of pixels over a valid/ready handshake and writes them, in raster order, into the pixel buffer that the display path later reads for the rectangle xL..xR, yU..yD. For every pixel it produces a buffer write strobe, a linear buffer address, the pixel data and the pixel's screen coordinates. It signals completion of the window and rejects invalid windows.

## Interface
- DATA_W, 12: pixel width (RGB 4:4:4)
- ADDR_W, 19: buffer address width (640*480 = 307200 fits in 19 bits)

- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start  input  1  begin a window write; sampled only in IDLE
- abort  input  1  cancel the frame in progress; return to IDLE
- xL, xR  input  10  window columns, valid range 0..639
- yU, yD  input  10  window rows, valid range 0..479
- pix_data  input  DATA_W  incoming pixel
- pix_valid  input  1  pix_data is valid
- pix_ready  output  1  block accepts a pixel this cycle
- wr_en  output  1  buffer write strobe
- wr_addr  output  ADDR_W  linear buffer address, 0-based within the window
- wr_data  output  DATA_W  data to write
- wr_x, wr_y  output  10  screen coordinates of the written pixel
- busy  output  1  a window is being written
- done  output  1  one-cycle pulse on the final write
- err  output  1  one-cycle pulse when start is rejected

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start, latch xL, xR, yU and yD.
  - Reject the window if xL>xR, yU>yD, xR>639 or yD>479. On rejection, pulse err for 1 cycle and stay in IDLE.
  - Otherwise go to RUN with col=xL, row=yU, addr=0.
- RUN:
  - pix_ready=1.
  - A handshake occurs when pix_valid&&pix_ready. On a handshake, register wr_en=1, wr_data=pix_data, wr_addr=addr, wr_x=col, wr_y=row.
  - Then advance the position:
    - If col==xR and row==yD, go to DONE.
    - Else if col==xR, set col=xL and row=row+1.
    - Else set col=col+1.
  - addr increments by 1 on every handshake.
- DONE: done=1 for exactly 1 cycle, then go to IDLE.
- wr_en is 0 in every cycle without a preceding handshake.
- Window inputs are ignored outside IDLE; changing them mid-frame has no effect.
- start in RUN or DONE is ignored.
- abort in RUN goes to IDLE on the next edge:
  - No done pulse.
  - A handshake in the same cycle as abort is still written.
  - Any later pixel is not accepted.
- abort has priority over the end-of-window transition. A final handshake coincident with abort is written, but done is not pulsed.
- Pixel count = (xR-xL+1)*(yD-yU+1). Arithmetic for the count and address is unsigned, ADDR_W bits, with no wrap because the maximum is 307199.
- Output decode:
  - busy = state is RUN or DONE.
  - pix_ready = state is RUN.
  - done = state is DONE.

## Timing
- Reset (asynchronous, at any time including mid-frame): state=IDLE; pix_ready, wr_en, busy, done and err are 0; wr_addr, wr_data, wr_x and wr_y are 0. The frame is lost.
- start is sampled at edge 0. busy and pix_ready are 1 from cycle 1.
- Write latency: a handshake at edge k gives wr_en, wr_addr, wr_data, wr_x and wr_y during cycle k..k+1.
- Final handshake at edge k: during cycle k..k+1, done=1, pix_ready=0 and wr_en=1 for the last pixel. The block is in IDLE from edge k+1, so no extra pixel is ever accepted.
- Throughput: 1 pixel/cycle with pix_valid held high. Minimum frame time is N+1 cycles from start to IDLE.
- err is asserted in cycle 0..1 after a rejected start.
- A start is accepted again in the cycle following DONE.

## Test plan
- **2x2 window.** xL=10, xR=11, yU=20, yD=21; pix_valid=1 with data 0x001..0x004.
  - Required: 4 consecutive wr_en, addr 0..3, wr_x=10,11,10,11, wr_y=20,20,21,21.
  - done coincides with addr 3; busy=0 afterward.
- **Backpressure.** Same window with pix_valid toggled 1,0,0,1,1,0,1.
  - Required: exactly 4 writes, each one cycle after a handshake, with data order preserved.
- **Single pixel.** xL=xR=639, yU=yD=479.
  - Required: 1 write at addr 0 with (639,479), and done in the same cycle.
- **Invalid windows.** xL=5, xR=4, then xR=640, then yD=480.
  - Required: err pulses 1 cycle each time; busy, pix_ready and wr_en stay 0.
- **Abort, ignored start, reset.**
  - abort after 3 pixels of a 4x4 window: 3 writes, no done, IDLE next cycle.
  - start while busy with different coordinates: ignored, and the original window completes.
  - rst_n low mid-frame: all outputs 0 immediately.
- **Full frame.** 0..639 x 0..479 with continuous valid.
  - Required: 307200 writes; last write addr 307199 at (639,479) with done; total 307201 cycles from start to IDLE.

Source files
------------

// File: rtl/window_pixel_writer.sv
// Writes a raster-ordered pixel stream into the display buffer for the window xL..xR, yU..yD.
// Each accepted pixel yields one registered write with a window-relative linear address and screen coordinates.
module window_pixel_writer #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 19
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [9:0]        xL,
   input  logic [9:0]        xR,
   input  logic [9:0]        yU,
   input  logic [9:0]        yD,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              pix_valid,
   output logic              pix_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [9:0]        wr_x,
   output logic [9:0]        wr_y,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        dbgState
);

   // Pixel handshake: a pixel transfers on a rising edge where pix_valid && pix_ready;
   // pix_valid may be dropped at any time, pix_ready is high for the whole RUN state.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, stateNext;
   logic [9:0]        xLq, xRq, yUq, yDq;
   logic [9:0]        col, row, colNext, rowNext;
   logic [ADDR_W-1:0] addr, addrNext;
   logic              winOk, handshake, lastPix, latchWin, errNext;

   always_comb begin
      stateNext = state;
      colNext   = col;
      rowNext   = row;
      addrNext  = addr;
      latchWin  = 1'b0;
      errNext   = 1'b0;
      winOk     = (xL <= xR) && (yU <= yD) && (xR <= 10'd639) && (yD <= 10'd479);
      handshake = (state == RUN) && pix_valid;
      lastPix   = (col == xRq) && (row == yDq);

      case (state)
         IDLE: begin
            if (start) begin
               latchWin = 1'b1;
               if (winOk) begin
                  stateNext = RUN;
                  colNext   = xL;
                  rowNext   = yU;
                  addrNext  = '0;
               end else begin
                  errNext = 1'b1;
               end
            end
         end
         RUN: begin
            if (handshake) begin
               addrNext = addr + 1'b1;
               if (lastPix) begin
                  stateNext = DONE;
               end else if (col == xRq) begin
                  colNext = xLq;
                  rowNext = row + 10'd1;
               end else begin
                  colNext = col + 10'd1;
               end
            end
            // abort wins over the end-of-window transition, suppressing done
            if (abort) stateNext = IDLE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         xLq   <= '0;
         xRq   <= '0;
         yUq   <= '0;
         yDq   <= '0;
         col   <= '0;
         row   <= '0;
         addr  <= '0;
      end else begin
         state <= stateNext;
         col   <= colNext;
         row   <= rowNext;
         addr  <= addrNext;
         if (latchWin) begin
            xLq <= xL;
            xRq <= xR;
            yUq <= yU;
            yDq <= yD;
         end
      end
   end

   // Write port is registered so the buffer sees a clean strobe one edge after the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         wr_x    <= '0;
         wr_y    <= '0;
         err     <= 1'b0;
      end else begin
         wr_en <= handshake;
         err   <= errNext;
         if (handshake) begin
            wr_addr <= addr;
            wr_data <= pix_data;
            wr_x    <= col;
            wr_y    <= row;
         end
      end
   end

   assign pix_ready = (state == RUN);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbgState  = state;

endmodule

// File: tb/tb_window_pixel_writer.sv
// Directed bench for window_pixel_writer: stimulus pushes expected writes, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_window_pixel_writer;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 19;
  localparam int W = 1 + ADDR_W + DATA_W + 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [9:0]        xL = '0, xR = '0, yU = '0, yD = '0;
  logic [DATA_W-1:0] pix_data = '0;
  logic              pix_valid = 1'b0;
  logic              pix_ready, wr_en, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [9:0]        wr_x, wr_y;
  logic [1:0]        dbgState;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int expErr = 0;
  int errSeen = 0;
  int cyc = 0;
  int winCount = 0;
  int sent = 0;
  logic [9:0] wxL, wxR, wyU, wyD;

  window_pixel_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .xL(xL), .xR(xR), .yU(yU), .yD(yD),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_x(wr_x), .wr_y(wr_y), .busy(busy), .done(done), .err(err),
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic startWin(input logic [9:0] xl, input logic [9:0] xr,
                          input logic [9:0] yu, input logic [9:0] yd, input bit ok);
    xL = xl; xR = xr; yU = yu; yD = yd;
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_after_start", err, !ok);
    check("busy_after_start", busy, ok);
    check("ready_after_start", pix_ready, ok);
    wxL = xl; wxR = xr; wyU = yu; wyD = yd;
    winCount = (int'(xr) - int'(xl) + 1) * (int'(yd) - int'(yu) + 1);
    sent = 0;
    if (!ok) begin
      expErr++;
      step();
      check("err_one_cycle", err, 0);
      check("busy_after_reject", busy, 0);
      check("wr_en_after_reject", wr_en, 0);
    end
  endtask

  task automatic feed(input int nPix, input logic [31:0] pat, input int patLen,
                      input int abortAt, input bit midStart);
    int i;
    int w;
    bit v;
    bit abrt;
    logic [DATA_W-1:0] d;
    logic [ADDR_W-1:0] a;
    logic [9:0] px, py;
    i = 0;
    abrt = 1'b0;
    w = int'(wxR) - int'(wxL) + 1;
    while (sent < nPix && !abrt) begin
      v = (patLen == 0) ? 1'b1 : pat[i % patLen];
      pix_valid = v;
      abort = 1'b0;
      if (midStart && i == 1) begin
        start = 1'b1; xL = 10'd0; xR = 10'd0; yU = 10'd0; yD = 10'd0;
      end else begin
        start = 1'b0;
      end
      check("ready_in_run", pix_ready, 1);
      if (v) begin
        d = DATA_W'(sent + 1);
        a = ADDR_W'(sent);
        px = wxL + 10'(sent % w);
        py = wyU + 10'(sent / w);
        abrt = (abortAt >= 0) && (sent == abortAt);
        pix_data = d;
        abort = abrt;
        exp_q.push_back({(sent == winCount - 1) && !abrt, a, d, px, py});
        sent++;
      end
      step();
      i++;
    end
    pix_valid = 1'b0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  // After the final handshake: one DONE cycle, then IDLE
  task automatic finishWin();
    check("done_cycle_ready", pix_ready, 0);
    check("done_cycle_busy", busy, 1);
    step();
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_ready", pix_ready, 0);
  endtask

  // scoreboard monitor
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] req;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        got = {done, wr_addr, wr_data, wr_x, wr_y};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%0d data=%h x=%0d y=%0d done=%0b, required no write",
                   wr_addr, wr_data, wr_x, wr_y, done);
        end else begin
          req = exp_q.pop_front();
          if (got !== req) begin
            errors++;
            $display("FAIL write: got done=%0b addr=%0d data=%h x=%0d y=%0d, required done=%0b addr=%0d data=%h x=%0d y=%0d",
                     got[W-1], got[W-2 -: ADDR_W], got[19+DATA_W -: DATA_W], got[19:10], got[9:0],
                     req[W-1], req[W-2 -: ADDR_W], req[19+DATA_W -: DATA_W], req[19:10], req[9:0]);
          end
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_without_write: done=1 wr_en=0, required done only with the final write");
      end
      if (err) errSeen++;
    end
  end

  initial begin
    int c0;
    #12;
    check("reset_busy", busy, 0);
    check("reset_ready", pix_ready, 0);
    check("reset_wr_en", wr_en, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_wr_addr", wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 2x2 window, continuous valid
    startWin(10'd10, 10'd11, 10'd20, 10'd21, 1'b1);
    feed(4, 32'd0, 0, -1, 1'b0);
    finishWin();

    // backpressure 1,0,0,1,1,0,1
    startWin(10'd10, 10'd11, 10'd20, 10'd21, 1'b1);
    feed(4, 32'b1011001, 7, -1, 1'b0);
    finishWin();

    // single pixel at the far corner
    startWin(10'd639, 10'd639, 10'd479, 10'd479, 1'b1);
    feed(1, 32'd0, 0, -1, 1'b0);
    finishWin();

    // invalid windows
    startWin(10'd5, 10'd4, 10'd0, 10'd0, 1'b0);
    startWin(10'd0, 10'd640, 10'd0, 10'd0, 1'b0);
    startWin(10'd0, 10'd0, 10'd0, 10'd480, 1'b0);

    // abort coincident with the third pixel of a 4x4 window
    startWin(10'd0, 10'd3, 10'd0, 10'd3, 1'b1);
    feed(16, 32'd0, 0, 2, 1'b0);
    check("abort_busy", busy, 0);
    check("abort_ready", pix_ready, 0);
    check("abort_done", done, 0);
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
    check("abort_no_write", wr_en, 0);
    step();

    // start with other coordinates while busy is ignored
    startWin(10'd100, 10'd101, 10'd100, 10'd101, 1'b1);
    feed(4, 32'd0, 0, -1, 1'b1);
    finishWin();

    // asynchronous reset mid-frame
    startWin(10'd0, 10'd3, 10'd0, 10'd3, 1'b1);
    feed(5, 32'd0, 0, -1, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_xy", {wr_x, wr_y}, 0);
    check("rst_pending", exp_q.size(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_busy", busy, 0);

    // large window ending at (639,479): frame time N+1 cycles
    startWin(10'd0, 10'd639, 10'd440, 10'd479, 1'b1);
    c0 = cyc;
    feed(25600, 32'd0, 0, -1, 1'b0);
    finishWin();
    check("frame_cycles", cyc - c0, 25601);

    step();
    step();
    check("queue_empty", exp_q.size(), 0);
    check("err_pulses", errSeen, expErr);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
